// File: rtl/channel_model.sv
// channel_model: baseband channel with 1-cycle latency, periodic LFSR noise and outage windows.
// Define CHANNEL_SAT_EN to saturate the signal+noise sum instead of wrapping.
module channel_model #(
  parameter int          DATA_W       = 9,
  parameter int          NOISE_W      = 5,
  parameter int          NOISE_PERIOD = 4,
  parameter int          PASS_LEN     = 12,
  parameter int          OUT_LEN      = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_transmit,
  input  logic                     noise_en,
  input  logic signed [DATA_W-1:0] channel_in,
  output logic signed [DATA_W-1:0] channel_out,
  output logic                     out_valid,
  output logic                     in_outage
);
  localparam int NC_W   = NOISE_PERIOD > 1 ? $clog2(NOISE_PERIOD) : 1;
  localparam int PH_MAX = PASS_LEN > OUT_LEN ? PASS_LEN : OUT_LEN;
  localparam int PH_W   = PH_MAX > 1 ? $clog2(PH_MAX) : 1;
  typedef enum logic {PASS, OUTAGE} state_t;
  state_t                   state_q;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [NC_W-1:0]          nc_q, nc_d;
  logic [PH_W-1:0]          ph_q;
  logic signed [DATA_W-1:0] out_q, out_d, term, res;
  logic signed [NOISE_W-1:0] noise_raw;
  logic                     valid_q, outage_q, inject, phase_end, sel_data;
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    inject    = noise_en && nc_q == NC_W'(NOISE_PERIOD - 1);
    nc_d      = nc_q == NC_W'(NOISE_PERIOD - 1) ? '0 : nc_q + 1'b1;
    noise_raw = lfsr_q[NOISE_W-1:0];
    term      = inject ? DATA_W'(noise_raw) : '0;
    phase_end = state_q == PASS ? ph_q == PH_W'(PASS_LEN - 1) : ph_q == PH_W'(OUT_LEN - 1);
    sel_data  = is_transmit && state_q == PASS;
    out_d     = sel_data ? res : term;
  end
`ifdef CHANNEL_SAT_EN
  logic signed [DATA_W:0] sum;
  always_comb begin
    sum = (DATA_W+1)'(channel_in) + (DATA_W+1)'(term);
    res = sum[DATA_W] != sum[DATA_W-1] ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
  end
`else
  assign res = channel_in + term;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q   <= LFSR_SEED;
      nc_q     <= '0;
      state_q  <= PASS;
      ph_q     <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      outage_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      nc_q     <= nc_d;
      ph_q     <= phase_end ? '0 : ph_q + 1'b1;
      // OUT_LEN of zero pins the FSM in PASS
      if (phase_end && OUT_LEN != 0) state_q <= state_q == PASS ? OUTAGE : PASS;
      out_q    <= out_d;
      valid_q  <= sel_data;
      outage_q <= state_q == OUTAGE;
    end
  end
  assign channel_out = out_q;
  assign out_valid   = valid_q;
  assign in_outage   = outage_q;
endmodule

// File: tb/tb_channel_model.sv
// tb_channel_model: directed + random stimulus against an arithmetic reference of the channel.
module tb_channel_model;
  logic clk = 1'b0, reset = 1'b0, is_transmit = 1'b0, noise_en = 1'b0;
  logic signed [8:0] channel_in = '0;
  logic signed [8:0] channel_out;
  logic out_valid, in_outage;
  int checks = 0, failures = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int m_edge = 0;
  channel_model dut (
    .clk(clk), .reset(reset), .is_transmit(is_transmit), .noise_en(noise_en),
    .channel_in(channel_in), .channel_out(channel_out), .out_valid(out_valid), .in_outage(in_outage)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, m_edge, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_edge = 0;
  endtask
  // One clock edge: predict from pre-edge model state and inputs, then compare #1 later.
  task automatic step();
    logic signed [4:0] nv;
    int term, s, e_out, e_val, e_out_g;
    bit pass;
    nv = m_lfsr[4:0];
    term = (noise_en && (m_edge % 4 == 3)) ? int'(nv) : 0;
    pass = (m_edge % 16) < 12;
    if (is_transmit && pass) begin
      s = int'(channel_in) + term;
`ifdef CHANNEL_SAT_EN
      e_out = s > 255 ? 255 : (s < -256 ? -256 : s);
`else
      e_out = s > 255 ? s - 512 : (s < -256 ? s + 512 : s);
`endif
      e_val = 1;
    end else begin
      e_out = term;
      e_val = 0;
    end
    e_out_g = pass ? 0 : 1;
    @(posedge clk);
    #1;
    check("channel_out", int'(channel_out), e_out);
    check("out_valid", int'(out_valid), e_val);
    check("in_outage", int'(in_outage), e_out_g);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_edge++;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, int'(channel_out), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_outage"}, int'(in_outage), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    is_transmit = 1'b1; noise_en = 1'b0; channel_in = 9'sd37;
    repeat (20) step();
    noise_en = 1'b1; channel_in = '0;
    repeat (24) step();
    noise_en = 1'b0; channel_in = -9'sd20;
    repeat (36) step();
    // Mid-run asynchronous reset, asserted away from any edge
    is_transmit = 1'b1; channel_in = 9'sd37;
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (20) step();
    is_transmit = 1'b1; noise_en = 1'b1; channel_in = 9'sd255;
    repeat (48) step();
    channel_in = -9'sd256;
    repeat (48) step();
    is_transmit = 1'b0; noise_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      channel_in = 9'($urandom);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      is_transmit = 1'($urandom);
      noise_en = 1'($urandom_range(0, 3) != 0);
      channel_in = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 9'sd255 : -9'sd256) : 9'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
